aes_encrypt_iter: RTL and testbench

- Iterative AES-128/192/256 encryption core, one round per clock.
- Replaces the combinational EncryptNK4/6/8 blocks with one parameterised core; key length is selected by NK.
- Sits beside the AES top level: plaintext and key are loaded with a start pulse, and ciphertext is returned with a done pulse.
- Round keys are expanded on the fly; no full key schedule is stored.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_round.sv | 29 ++
 rtl/aes_encrypt_iter.sv | 152 +++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, tables and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Rcon is 1-based in the key schedule; out-of-range indices yield zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] j);
    logic [3:0] idx;
    idx = j - 4'd1;
    if (j == 4'd0 || j > 4'd10) return 8'h00;
    return RCON[idx];
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  state_t       state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output state_t       state_out
);

  state_t shifted;
  state_t mixed;

  genvar gi;

  // Output byte at (row, col) takes the substituted byte from (row, col+row mod 4).
  for (gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * (((gi / 4) + ROW) % 4) + ROW;
    assign shifted[127-8*gi -: 8] = SBOX[state_in[127-8*SRC -: 8]];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    assign mixed[127-32*gi -: 32] = mix_column(shifted[127-32*gi -: 32]);
  end

  assign state_out = (final_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption, one round per clock, on-the-fly key expansion.
// Define AES_STATE_TAP_EN to expose the live state register and round counter.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [127:0]      PlainText,
  input  logic [32*NK-1:0]  Key,
  output logic [127:0]      Out,
  output logic              Done,
  output logic              Busy
`ifdef AES_STATE_TAP_EN
  ,
  output logic [127:0]      CurrentState,
  output logic [3:0]        Round
`endif
);

  localparam int NR = NK + 6;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: NK must be 4, 6 or 8");
  end

  fsm_t         fsm_reg, fsm_next;
  state_t       state_reg;
  state_t       round_out;
  logic [3:0]   round_reg;
  logic [31:0]  win_reg  [0:NK-1];
  logic [31:0]  win_next [0:NK-1];
  logic [2:0]   rem_reg, rem_next;
  logic [3:0]   quo_reg, quo_next;
  logic [127:0] out_reg;
  logic         done_reg;
  logic [127:0] round_key;
  logic         load, step, finish;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) fsm_reg <= ST_IDLE;
    else        fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      ST_IDLE: if (Start) fsm_next = ST_RUN;
      ST_RUN:  if (round_reg == 4'(NR)) fsm_next = ST_IDLE;
      default: fsm_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    Busy   = 1'b0;
    case (fsm_reg)
      ST_IDLE: load = Start;
      ST_RUN: begin
        step   = 1'b1;
        Busy   = 1'b1;
        finish = (round_reg == 4'(NR));
      end
      default: ;
    endcase
  end

  // The window holds w[g-NK..g-1]; appending the next four words gives
  // w[4r-4 .. 4r+NK-1], so this round's key always sits at positions 4..7.
  always_comb begin : key_expand
    logic [31:0] ext [0:NK+3];
    logic [31:0] temp;
    logic [2:0]  rem;
    logic [3:0]  quo;
    for (int j = 0; j < NK; j++) ext[j] = win_reg[j];
    for (int j = NK; j < NK + 4; j++) ext[j] = '0;
    rem  = rem_reg;
    quo  = quo_reg;
    temp = '0;
    for (int t = 0; t < 4; t++) begin
      if (rem == 3'd0)
        temp = sub_word(rot_word(ext[NK+t-1])) ^ {rcon_of(quo), 24'h000000};
      else if (NK == 8 && rem == 3'd4)
        temp = sub_word(ext[NK+t-1]);
      else
        temp = ext[NK+t-1];
      ext[NK+t] = ext[t] ^ temp;
      if (rem == 3'(NK - 1)) begin
        rem = 3'd0;
        quo = quo + 4'd1;
      end else begin
        rem = rem + 3'd1;
      end
    end
    round_key = {ext[4], ext[5], ext[6], ext[7]};
    for (int j = 0; j < NK; j++) win_next[j] = ext[j+4];
    rem_next = rem;
    quo_next = quo;
  end

  aes_round u_round (
    .state_in    (state_reg),
    .round_key   (round_key),
    .final_round (finish),
    .state_out   (round_out)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= '0;
      round_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
      for (int j = 0; j < NK; j++) win_reg[j] <= '0;
    end else begin
      done_reg <= finish;
      if (load) begin
        state_reg <= PlainText ^ Key[32*NK-1 -: 128];
        for (int j = 0; j < NK; j++) win_reg[j] <= Key[32*(NK-j)-1 -: 32];
        round_reg <= 4'd1;
        rem_reg   <= 3'd0;
        quo_reg   <= 4'd1;
      end else if (step) begin
        state_reg <= round_out;
        for (int j = 0; j < NK; j++) win_reg[j] <= win_next[j];
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        if (finish) begin
          round_reg <= '0;
          out_reg   <= round_out;
        end else begin
          round_reg <= round_reg + 4'd1;
        end
      end
    end
  end

  assign Out  = out_reg;
  assign Done = done_reg;

`ifdef AES_STATE_TAP_EN
  assign CurrentState = state_reg;
  assign Round        = round_reg;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed FIPS-197 vectors for NK=4/6/8 plus back-to-back, mid-run restart and abort sequences.
module tb_aes_encrypt_iter;

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] pt;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         start4, start6, start8;
  logic [127:0] out4, out6, out8;
  logic         done4, done6, done8;
  logic         busy4, busy6, busy8;
`ifdef AES_STATE_TAP_EN
  logic [127:0] cs4, cs6, cs8;
  logic [3:0]   rd4, rd6, rd8;
`endif

  int passed = 0;
  int total  = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  aes_encrypt_iter #(.NK(4)) u_nk4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start4), .PlainText(pt), .Key(key4),
    .Out(out4), .Done(done4), .Busy(busy4)
`ifdef AES_STATE_TAP_EN
    , .CurrentState(cs4), .Round(rd4)
`endif
  );

  aes_encrypt_iter #(.NK(6)) u_nk6 (
    .Clk(clk), .Rst_n(rst_n), .Start(start6), .PlainText(pt), .Key(key6),
    .Out(out6), .Done(done6), .Busy(busy6)
`ifdef AES_STATE_TAP_EN
    , .CurrentState(cs6), .Round(rd6)
`endif
  );

  aes_encrypt_iter #(.NK(8)) u_nk8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start8), .PlainText(pt), .Key(key8),
    .Out(out8), .Done(done8), .Busy(busy8)
`ifdef AES_STATE_TAP_EN
    , .CurrentState(cs8), .Round(rd8)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic done_of(input int nk);
    case (nk)
      4:       return done4;
      6:       return done6;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_of(input int nk);
    case (nk)
      4:       return busy4;
      6:       return busy6;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [127:0] out_of(input int nk);
    case (nk)
      4:       return out4;
      6:       return out6;
      default: return out8;
    endcase
  endfunction

  task automatic set_start(input int nk, input logic v);
    case (nk)
      4:       start4 = v;
      6:       start6 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic load_inputs(input vec_t v);
    pt   = v.pt;
    key4 = v.key[255:128];
    key6 = v.key[255:64];
    key8 = v.key;
  endtask

  // Called on the negedge right after the Start edge; counts edges until Done.
  task automatic wait_done(input int nk, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_of(nk) && cyc < 40);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    load_inputs(v);
    set_start(v.nk, 1'b1);
    @(negedge clk);
    set_start(v.nk, 1'b0);
    check({name, " busy_after_start"}, 128'(busy_of(v.nk)), 128'd1);
    wait_done(v.nk, cyc);
    check({name, " latency"}, 128'(cyc), 128'(v.nk + 6));
    check({name, " out"}, out_of(v.nk), v.ct);
    check({name, " busy_at_done"}, 128'(busy_of(v.nk)), 128'd0);
    $display("%s: nk=%0d latency=%0d out=%h", name, v.nk, cyc, out_of(v.nk));
    @(negedge clk);
    check({name, " done_one_cycle"}, 128'(done_of(v.nk)), 128'd0);
    check({name, " out_hold"}, out_of(v.nk), v.ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic seen;

    vecs[0] = '{nk: 4, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                pt: 128'h00112233445566778899aabbccddeeff, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{nk: 6, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                pt: 128'h00112233445566778899aabbccddeeff, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{nk: 8, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                pt: 128'h00112233445566778899aabbccddeeff, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{nk: 4, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                pt: 128'h3243f6a8885a308d313198a2e0370734, ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[4] = '{nk: 4, key: 256'h0,
                pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n  = 1'b0;
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    pt     = '0;
    key4   = '0;
    key6   = '0;
    key8   = '0;
    repeat (2) @(negedge clk);
    for (int n = 4; n <= 8; n += 2) begin
      check($sformatf("reset nk%0d out", n), out_of(n), 128'd0);
      check($sformatf("reset nk%0d done", n), 128'(done_of(n)), 128'd0);
      check($sformatf("reset nk%0d busy", n), 128'(busy_of(n)), 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second Start raised during the first block's Done cycle.
    load_inputs(vecs[3]);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(4, cyc);
    check("b2b first latency", 128'(cyc), 128'd10);
    check("b2b first out", out4, vecs[3].ct);
    $display("b2b_first: nk=4 latency=%0d out=%h", cyc, out4);
    load_inputs(vecs[0]);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("b2b done pulse width", 128'(done4), 128'd0);
    check("b2b second accepted", 128'(busy4), 128'd1);
    wait_done(4, cyc);
    check("b2b second latency", 128'(cyc), 128'd10);
    check("b2b second out", out4, vecs[0].ct);
    $display("b2b_second: nk=4 latency=%0d out=%h", cyc, out4);
    @(negedge clk);
    check("b2b second done width", 128'(done4), 128'd0);

    // Start re-pulsed with different inputs while busy must be ignored.
    load_inputs(vecs[3]);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done4) seen = 1'b1;
      else if (cyc == 3) begin
        pt     = ~pt;
        key4   = ~key4;
        start4 = 1'b1;
      end else if (cyc == 4) start4 = 1'b0;
    end
    check("midstart latency", 128'(cyc), 128'd10);
    check("midstart out", out4, vecs[3].ct);
    $display("midstart: nk=4 latency=%0d out=%h", cyc, out4);
    @(negedge clk);
    check("midstart no restart", 128'(busy4), 128'd0);

    // Asynchronous reset in the middle of a block aborts it.
    load_inputs(vecs[0]);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out cleared", out4, 128'd0);
    check("abort busy cleared", 128'(busy4), 128'd0);
    check("abort done low", 128'(done4), 128'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("abort no done", 128'(seen), 128'd0);
    check("abort out stays zero", out4, 128'd0);
    $display("abort: nk=4 done_seen=%0d out=%h", seen, out4);
    run_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
